// File: rtl/conv1d_mc_core.sv
// Multi-channel 1D convolution core: streamed N_CH-channel samples, runtime kernel length and stride,
// one signed channel+tap sum per output position. Define CONV1D_RELU_EN to clamp negative sums to 0.
`timescale 1ns/1ps
module conv1d_mc_core #(
   parameter int DATA_W     = 8,
   parameter int COEF_W     = 8,
   parameter int ACC_W      = 24,
   parameter int N_CH       = 4,
   parameter int K_MAX      = 8,
   parameter int STRIDE_MAX = 4,
   parameter int LEN_W      = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              start_i,
   input  logic                              abort_i,
   input  logic [$clog2(K_MAX+1)-1:0]        cfg_klen_i,
   input  logic [$clog2(STRIDE_MAX+1)-1:0]   cfg_stride_i,
   input  logic [LEN_W-1:0]                  cfg_nsamp_i,
   input  logic                              coef_we_i,
   input  logic [$clog2(N_CH)-1:0]           coef_ch_i,
   input  logic [$clog2(K_MAX)-1:0]          coef_idx_i,
   input  logic [COEF_W-1:0]                 coef_data_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [N_CH*DATA_W-1:0]            in_data_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [ACC_W-1:0]                  out_data_o,
   output logic                              running_o,
   output logic                              done_o,
   output logic                              err_o,
   input  logic                              int_en_i,
   input  logic                              int_clr_i,
   output logic                              done_int_o
);

   localparam int KW = $clog2(K_MAX+1);
   localparam int SW = $clog2(STRIDE_MAX+1);
   localparam int IW = $clog2(K_MAX);

   generate
      if (ACC_W < DATA_W + COEF_W + $clog2(N_CH*K_MAX)) begin : g_acc_chk
         $error("conv1d_mc_core: ACC_W too narrow for N_CH*K_MAX products");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
   state_e state_q, state_d;

   logic [KW-1:0]            klen_q;
   logic [SW-1:0]            stride_q, ph_q, ph_n;
   logic [LEN_W-1:0]         nsamp_q, rx_q, rx_n;
   logic signed [COEF_W-1:0] coef_q [N_CH][K_MAX];
   logic signed [DATA_W-1:0] win_q  [N_CH][K_MAX];
   logic signed [DATA_W-1:0] win_n  [N_CH][K_MAX];
   logic signed [ACC_W-1:0]  sum, res;
   logic [IW-1:0]            tap;
   logic                     cfg_bad, accept_start, beat, fire, done_d;

   assign cfg_bad = (cfg_klen_i == '0) || (cfg_klen_i > KW'(K_MAX)) ||
                    (cfg_stride_i == '0) || (cfg_stride_i > SW'(STRIDE_MAX));
   assign accept_start = (state_q == S_IDLE) && start_i;
   assign in_ready_o   = (state_q == S_RUN) && (!out_valid_o || out_ready_i);
   assign beat         = in_valid_i && in_ready_o;
   assign running_o    = (state_q == S_RUN) || (state_q == S_DRAIN);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path holds an old value (no latch).
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (cfg_bad) done_d = 1'b1;
               else state_d = (cfg_nsamp_i == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN:   if (beat && rx_n == nsamp_q) state_d = S_DRAIN;
         S_DRAIN: begin
            if (!out_valid_o || out_ready_i) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_i && state_q != S_IDLE) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   // Window as it will look after this beat, its stride bookkeeping, and the sum over it.
   always_comb begin
      // NOTE: blocking '=' here so the sum accumulates in loop order; clocked state below uses '<='.
      rx_n = rx_q + LEN_W'(1);
      ph_n = ph_q;
      fire = 1'b0;
      tap  = '0;
      sum  = '0;
      if (rx_n == LEN_W'(klen_q)) begin
         fire = beat;
         ph_n = '0;
      end else if (rx_n > LEN_W'(klen_q)) begin
         ph_n = ph_q + SW'(1);
         if (ph_n == stride_q) begin
            fire = beat;
            ph_n = '0;
         end
      end
      for (int c = 0; c < N_CH; c++) begin
         win_n[c][0] = in_data_i[c*DATA_W +: DATA_W];
         for (int k = 1; k < K_MAX; k++) win_n[c][k] = win_q[c][k-1];
      end
      for (int c = 0; c < N_CH; c++) begin
         for (int k = 0; k < K_MAX; k++) begin
            if (k < int'(klen_q)) begin
               tap = IW'(int'(klen_q) - 1 - k);
               sum = sum + ACC_W'(coef_q[c][k]) * ACC_W'(win_n[c][tap]);
            end
         end
      end
`ifdef CONV1D_RELU_EN
      res = sum[ACC_W-1] ? '0 : sum;
`else
      res = sum;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: coefficient file and window are reset deliberately; a run must never see stale taps.
         for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < K_MAX; k++) begin
               coef_q[c][k] <= '0;
               win_q[c][k]  <= '0;
            end
         end
         klen_q      <= '0;
         stride_q    <= '0;
         nsamp_q     <= '0;
         rx_q        <= '0;
         ph_q        <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         done_int_o  <= 1'b0;
      end else begin
         done_o <= done_d;
         if (state_q == S_IDLE && coef_we_i) coef_q[coef_ch_i][coef_idx_i] <= coef_data_i;
         if (accept_start) begin
            err_o    <= cfg_bad;
            klen_q   <= cfg_klen_i;
            stride_q <= cfg_stride_i;
            nsamp_q  <= cfg_nsamp_i;
            rx_q     <= '0;
            ph_q     <= '0;
            for (int c = 0; c < N_CH; c++)
               for (int k = 0; k < K_MAX; k++) win_q[c][k] <= '0;
         end
         if (beat) begin
            win_q <= win_n;
            rx_q  <= rx_n;
            ph_q  <= ph_n;
         end
         if (fire) begin
            out_data_o  <= res;
            out_valid_o <= 1'b1;
         end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
         end
         if (abort_i && state_q != S_IDLE) out_valid_o <= 1'b0;
         // Set beats clear when both land in the same cycle.
         if (done_o && int_en_i)              done_int_o <= 1'b1;
         else if (int_clr_i || accept_start)  done_int_o <= 1'b0;
      end
   end

endmodule
